// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the accumulator-CPU control sequencer:
// state encoding, opcode constants and a small opcode helper.
package cpu_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC1 = 3'd2,
        S_EXEC2 = 3'd3,
        S_HALT  = 3'd4
    } seq_state_t;

    localparam logic [3:0] OP_LDA = 4'd0;
    localparam logic [3:0] OP_STA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_JMI = 4'd5;
    localparam logic [3:0] OP_JEQ = 4'd6;
    localparam logic [3:0] OP_STP = 4'd7;
    localparam logic [3:0] OP_LDI = 4'd8;

    // STP is the only opcode that ends execution permanently.
    function automatic logic is_stop_op(input logic [3:0] op);
        return (op == OP_STP);
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Run-control / phase-strobe bundle between the CPU controller and the sequencer.
// The STEP request only exists when SEQ_STEP_EN is defined.
interface cpu_sequencer_if #(
    parameter int CNT_W = 16
) ();
    import cpu_seq_pkg::*;

    logic             START;
    logic             STOP;
    logic [3:0]       IR;
    logic             EXTRA;
`ifdef SEQ_STEP_EN
    logic             STEP;
`endif
    logic             FETCH;
    logic             EXEC1;
    logic             EXEC2;
    logic             RUNNING;
    logic             HALTED;
    logic [CNT_W-1:0] CYCLE_CNT;
    logic [CNT_W-1:0] INSTR_CNT;

    modport master (
`ifdef SEQ_STEP_EN
        output STEP,
`endif
        output START, STOP, IR, EXTRA,
        input  FETCH, EXEC1, EXEC2, RUNNING, HALTED, CYCLE_CNT, INSTR_CNT
    );

    modport slave (
`ifdef SEQ_STEP_EN
        input  STEP,
`endif
        input  START, STOP, IR, EXTRA,
        output FETCH, EXEC1, EXEC2, RUNNING, HALTED, CYCLE_CNT, INSTR_CNT
    );

endinterface

// File: rtl/cpu_sequencer_sat_counter.sv
// Saturating up-counter with synchronous active-high reset; sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         INC,
    output logic [W-1:0] Q
);
    localparam logic [W-1:0] MAX_VAL = {W{1'b1}};
    localparam logic [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] r_q;

    // Count up on INC, holding once the maximum value is reached.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_q <= '0;
        end else if (INC && (r_q != MAX_VAL)) begin
            r_q <= r_q + ONE;
        end else begin
            r_q <= r_q;
        end
    end

    assign Q = r_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Control-state sequencer for the 4-bit-opcode accumulator CPU.
// Produces one-hot FETCH/EXEC1/EXEC2 strobes, run/stop control at instruction
// boundaries, halts on STP, and keeps saturating cycle/instruction counters.
// Optional single-step run control is enabled by defining SEQ_STEP_EN.
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input logic            CLK,
    input logic            RESET,
    cpu_sequencer_if.slave sif
);

    seq_state_t r_state;
    seq_state_t w_next_state;
    logic       r_stop_pend;
    logic       w_stop_pend_next;
    logic       w_instr_done;
    logic       w_to_idle;
    logic       r_fetch;
    logic       r_exec1;
    logic       r_exec2;
    logic       r_running;
    logic       r_halted;
`ifdef SEQ_STEP_EN
    logic       r_step_pend;
    logic       w_step_pend_next;
`endif

    // Next-state, pending-flag and instruction-retire decode.
    always_comb begin
        w_next_state     = r_state;
        w_stop_pend_next = r_stop_pend;
        w_instr_done     = 1'b0;
`ifdef SEQ_STEP_EN
        w_step_pend_next = r_step_pend;
        w_to_idle        = r_stop_pend | sif.STOP | r_step_pend;
`else
        w_to_idle        = r_stop_pend | sif.STOP;
`endif
        case (r_state)
            S_IDLE: begin
                w_stop_pend_next = 1'b0;
`ifdef SEQ_STEP_EN
                w_step_pend_next = 1'b0;
`endif
                if (sif.START) begin
                    w_next_state = S_FETCH;
`ifdef SEQ_STEP_EN
                end else if (sif.STEP) begin
                    w_next_state     = S_FETCH;
                    w_step_pend_next = 1'b1;
`endif
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_FETCH: begin
                w_next_state     = S_EXEC1;
                w_stop_pend_next = r_stop_pend | sif.STOP;
            end
            S_EXEC1: begin
                if (is_stop_op(sif.IR)) begin
                    // PC is not advanced by STP, so there is nothing to resume.
                    w_next_state = S_HALT;
                end else if (sif.EXTRA) begin
                    w_next_state     = S_EXEC2;
                    w_stop_pend_next = r_stop_pend | sif.STOP;
                end else begin
                    w_instr_done = 1'b1;
                    if (w_to_idle) begin
                        w_next_state     = S_IDLE;
                        w_stop_pend_next = 1'b0;
`ifdef SEQ_STEP_EN
                        w_step_pend_next = 1'b0;
`endif
                    end else begin
                        w_next_state = S_FETCH;
                    end
                end
            end
            S_EXEC2: begin
                w_instr_done = 1'b1;
                if (w_to_idle) begin
                    w_next_state     = S_IDLE;
                    w_stop_pend_next = 1'b0;
`ifdef SEQ_STEP_EN
                    w_step_pend_next = 1'b0;
`endif
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_HALT: begin
                w_next_state = S_HALT;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register with outputs registered from the next-state decode.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_stop_pend <= 1'b0;
`ifdef SEQ_STEP_EN
            r_step_pend <= 1'b0;
`endif
            r_fetch     <= 1'b0;
            r_exec1     <= 1'b0;
            r_exec2     <= 1'b0;
            r_running   <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_stop_pend <= w_stop_pend_next;
`ifdef SEQ_STEP_EN
            r_step_pend <= w_step_pend_next;
`endif
            r_fetch     <= (w_next_state == S_FETCH);
            r_exec1     <= (w_next_state == S_EXEC1);
            r_exec2     <= (w_next_state == S_EXEC2);
            r_running   <= (w_next_state == S_FETCH) || (w_next_state == S_EXEC1) ||
                           (w_next_state == S_EXEC2);
            r_halted    <= (w_next_state == S_HALT);
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .CLK   (CLK),
        .RESET (RESET),
        .INC   (r_running),
        .Q     (sif.CYCLE_CNT)
    );

    sat_counter #(.W(CNT_W)) u_instr_cnt (
        .CLK   (CLK),
        .RESET (RESET),
        .INC   (w_instr_done),
        .Q     (sif.INSTR_CNT)
    );

    assign sif.FETCH   = r_fetch;
    assign sif.EXEC1   = r_exec1;
    assign sif.EXEC2   = r_exec2;
    assign sif.RUNNING = r_running;
    assign sif.HALTED  = r_halted;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed testbench for cpu_sequencer: a CNT_W=16 instance plus a CNT_W=4
// instance sharing the same stimulus for the saturation check.
module tb_cpu_sequencer;
    import cpu_seq_pkg::*;

    // Status vector order: {FETCH, EXEC1, EXEC2, RUNNING, HALTED}
    localparam logic [4:0] ST_IDLE  = 5'b00000;
    localparam logic [4:0] ST_FETCH = 5'b10010;
    localparam logic [4:0] ST_EXEC1 = 5'b01010;
    localparam logic [4:0] ST_EXEC2 = 5'b00110;
    localparam logic [4:0] ST_HALT  = 5'b00001;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;
    logic [36:0] obs;
    logic [36:0] exp_v;
    logic [12:0] obs4;
    logic [12:0] exp4;

    cpu_sequencer_if #(.CNT_W(16)) sif ();
    cpu_sequencer_if #(.CNT_W(4))  sif4 ();

    cpu_sequencer #(.CNT_W(16)) dut (.CLK(clk), .RESET(rst), .sif(sif.slave));
    cpu_sequencer #(.CNT_W(4))  dut4 (.CLK(clk), .RESET(rst), .sif(sif4.slave));

    assign sif4.START = sif.START;
    assign sif4.STOP  = sif.STOP;
    assign sif4.IR    = sif.IR;
    assign sif4.EXTRA = sif.EXTRA;
`ifdef SEQ_STEP_EN
    assign sif4.STEP  = sif.STEP;
`endif

    assign obs  = {sif.FETCH, sif.EXEC1, sif.EXEC2, sif.RUNNING, sif.HALTED,
                   sif.CYCLE_CNT, sif.INSTR_CNT};
    assign obs4 = {sif4.FETCH, sif4.EXEC1, sif4.EXEC2, sif4.RUNNING, sif4.HALTED,
                   sif4.CYCLE_CNT, sif4.INSTR_CNT};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        sif.START = 1'b0; sif.STOP = 1'b0; sif.IR = OP_LDA; sif.EXTRA = 1'b0;
        do_reset();
        exp_v = {ST_IDLE, 16'd0, 16'd0};
        n_chk++; if (obs !== exp_v) begin n_err++; $display("FAIL reset_state: got %h want %h", obs, exp_v); end
        // STOP in IDLE must not leave a pending stop behind.
        sif.STOP = 1'b1; tick(); sif.STOP = 1'b0;
        exp_v = {ST_IDLE, 16'd0, 16'd0};
        n_chk++; if (obs !== exp_v) begin n_err++; $display("FAIL idle_stop_hold: got %h want %h", obs, exp_v); end
        sif.START = 1'b1; sif.IR = OP_LDI; tick(); sif.START = 1'b0;
        tick(); tick();
        exp_v = {ST_FETCH, 16'd2, 16'd1};
        n_chk++; if (obs !== exp_v) begin n_err++; $display("FAIL idle_stop_ignored: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_ldi();
        do_reset();
        sif.START = 1'b1; sif.IR = OP_LDI; sif.EXTRA = 1'b0;
        tick(); sif.START = 1'b0;
        exp_v = {ST_FETCH, 16'd0, 16'd0};
        n_chk++; if (obs !== exp_v) begin n_err++; $display("FAIL ldi_c1: got %h want %h", obs, exp_v); end
        tick();
        exp_v = {ST_EXEC1, 16'd1, 16'd0};
        n_chk++; if (obs !== exp_v) begin n_err++; $display("FAIL ldi_c2: got %h want %h", obs, exp_v); end
        tick();
        exp_v = {ST_FETCH, 16'd2, 16'd1};
        n_chk++; if (obs !== exp_v) begin n_err++; $display("FAIL ldi_c3: got %h want %h", obs, exp_v); end
        tick();
        exp_v = {ST_EXEC1, 16'd3, 16'd1};
        n_chk++; if (obs !== exp_v) begin n_err++; $display("FAIL ldi_c4: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_extra();
        do_reset();
        sif.START = 1'b1; sif.IR = OP_ADD; sif.EXTRA = 1'b1;
        tick(); sif.START = 1'b0;
        tick();
        exp_v = {ST_EXEC1, 16'd1, 16'd0};
        n_chk++; if (obs !== exp_v) begin n_err++; $display("FAIL extra_exec1: got %h want %h", obs, exp_v); end
        tick();
        exp_v = {ST_EXEC2, 16'd2, 16'd0};
        n_chk++; if (obs !== exp_v) begin n_err++; $display("FAIL extra_exec2: got %h want %h", obs, exp_v); end
        tick();
        exp_v = {ST_FETCH, 16'd3, 16'd1};
        n_chk++; if (obs !== exp_v) begin n_err++; $display("FAIL extra_fetch2: got %h want %h", obs, exp_v); end
        tick(); tick(); tick();
        exp_v = {ST_FETCH, 16'd6, 16'd2};
        n_chk++; if (obs !== exp_v) begin n_err++; $display("FAIL extra_fetch3: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_stop();
        do_reset();
        sif.START = 1'b1; sif.IR = OP_LDA; sif.EXTRA = 1'b1;
        tick(); sif.START = 1'b0; sif.STOP = 1'b1;
        tick(); sif.STOP = 1'b0;
        tick();
        exp_v = {ST_EXEC2, 16'd2, 16'd0};
        n_chk++; if (obs !== exp_v) begin n_err++; $display("FAIL stop_exec2: got %h want %h", obs, exp_v); end
        tick();
        exp_v = {ST_IDLE, 16'd3, 16'd1};
        n_chk++; if (obs !== exp_v) begin n_err++; $display("FAIL stop_idle: got %h want %h", obs, exp_v); end
        tick();
        exp_v = {ST_IDLE, 16'd3, 16'd1};
        n_chk++; if (obs !== exp_v) begin n_err++; $display("FAIL stop_idle_hold: got %h want %h", obs, exp_v); end
        sif.START = 1'b1; tick(); sif.START = 1'b0;
        exp_v = {ST_FETCH, 16'd3, 16'd1};
        n_chk++; if (obs !== exp_v) begin n_err++; $display("FAIL stop_restart: got %h want %h", obs, exp_v); end
        tick(); tick(); tick();
        exp_v = {ST_FETCH, 16'd6, 16'd2};
        n_chk++; if (obs !== exp_v) begin n_err++; $display("FAIL stop_cleared: got %h want %h", obs, exp_v); end
        tick(); tick();
        // START and STOP together at the boundary: STOP wins.
        sif.START = 1'b1; sif.STOP = 1'b1; tick(); sif.STOP = 1'b0;
        exp_v = {ST_IDLE, 16'd9, 16'd3};
        n_chk++; if (obs !== exp_v) begin n_err++; $display("FAIL stop_beats_start: got %h want %h", obs, exp_v); end
        tick(); sif.START = 1'b0;
        exp_v = {ST_FETCH, 16'd9, 16'd3};
        n_chk++; if (obs !== exp_v) begin n_err++; $display("FAIL start_after_stop: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_halt();
        do_reset();
        sif.START = 1'b1; sif.IR = OP_STP; sif.EXTRA = 1'b1;
        tick(); sif.START = 1'b0;
        tick(); tick();
        exp_v = {ST_HALT, 16'd2, 16'd0};
        n_chk++; if (obs !== exp_v) begin n_err++; $display("FAIL halt_enter: got %h want %h", obs, exp_v); end
        for (int i = 0; i < 10; i++) begin
            sif.START = i[0]; sif.STOP = ~i[0]; sif.IR = 4'(i);
            tick();
            exp_v = {ST_HALT, 16'd2, 16'd0};
            n_chk++; if (obs !== exp_v) begin n_err++; $display("FAIL halt_hold%0d: got %h want %h", i, obs, exp_v); end
        end
        sif.START = 1'b0; sif.STOP = 1'b0;
        do_reset();
        exp_v = {ST_IDLE, 16'd0, 16'd0};
        n_chk++; if (obs !== exp_v) begin n_err++; $display("FAIL halt_reset: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        sif.START = 1'b1; sif.IR = OP_ADD; sif.EXTRA = 1'b1;
        tick(); sif.START = 1'b0;
        tick(); tick();
        exp_v = {ST_EXEC2, 16'd2, 16'd0};
        n_chk++; if (obs !== exp_v) begin n_err++; $display("FAIL mid_pre: got %h want %h", obs, exp_v); end
        sif.START = 1'b1;
        do_reset();
        sif.START = 1'b0;
        exp_v = {ST_IDLE, 16'd0, 16'd0};
        n_chk++; if (obs !== exp_v) begin n_err++; $display("FAIL mid_reset: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        sif.START = 1'b1; sif.IR = OP_LDI; sif.EXTRA = 1'b0;
        for (int i = 0; i < 21; i++) tick();
        exp4 = {ST_FETCH, 4'd15, 4'd10};
        n_chk++; if (obs4 !== exp4) begin n_err++; $display("FAIL sat4_c20: got %h want %h", obs4, exp4); end
        exp_v = {ST_FETCH, 16'd20, 16'd10};
        n_chk++; if (obs !== exp_v) begin n_err++; $display("FAIL b2b_c20: got %h want %h", obs, exp_v); end
        for (int i = 0; i < 20; i++) tick();
        exp4 = {ST_FETCH, 4'd15, 4'd15};
        n_chk++; if (obs4 !== exp4) begin n_err++; $display("FAIL sat4_c40: got %h want %h", obs4, exp4); end
        exp_v = {ST_FETCH, 16'd40, 16'd20};
        n_chk++; if (obs !== exp_v) begin n_err++; $display("FAIL b2b_c40: got %h want %h", obs, exp_v); end
        sif.START = 1'b0;
    endtask

`ifdef SEQ_STEP_EN
    task automatic test_step();
        do_reset();
        sif.STEP = 1'b1; sif.IR = OP_STA; sif.EXTRA = 1'b0;
        tick(); sif.STEP = 1'b0;
        exp_v = {ST_FETCH, 16'd0, 16'd0};
        n_chk++; if (obs !== exp_v) begin n_err++; $display("FAIL step_fetch: got %h want %h", obs, exp_v); end
        tick(); sif.START = 1'b1;
        tick();
        exp_v = {ST_IDLE, 16'd2, 16'd1};
        n_chk++; if (obs !== exp_v) begin n_err++; $display("FAIL step_idle: got %h want %h", obs, exp_v); end
        sif.START = 1'b0; tick();
        sif.START = 1'b1; sif.STEP = 1'b1;
        tick(); sif.START = 1'b0; sif.STEP = 1'b0;
        tick(); tick();
        exp_v = {ST_FETCH, 16'd4, 16'd2};
        n_chk++; if (obs !== exp_v) begin n_err++; $display("FAIL step_start_prio: got %h want %h", obs, exp_v); end
    endtask
`endif

    initial begin
        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        sif.START = 1'b0; sif.STOP = 1'b0; sif.IR = OP_LDA; sif.EXTRA = 1'b0;
`ifdef SEQ_STEP_EN
        sif.STEP = 1'b0;
`endif
        test_reset();
        test_ldi();
        test_extra();
        test_stop();
        test_halt();
        test_reset_mid();
        test_back_to_back();
`ifdef SEQ_STEP_EN
        test_step();
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
